// File: rtl/frame_store_arbiter.sv
// frame_store_arbiter: round-robin arbiter that puts two masters (edge
// detector "de" and host "hs") onto one single-ported synchronous SRAM.
// Each transaction takes IDLE -> ACCESS -> RESP, with a one-cycle ack in RESP.
module frame_store_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  de_req,
    output logic                  de_ack,
    input  logic [ADDR_W-1:0]     de_addr,
    input  logic [DATA_W/8-1:0]   de_nbyte,
    input  logic                  de_rnw,
    input  logic [DATA_W-1:0]     de_w_data,
    output logic [DATA_W-1:0]     de_r_data,

    input  logic                  hs_req,
    output logic                  hs_ack,
    input  logic [ADDR_W-1:0]     hs_addr,
    input  logic [DATA_W/8-1:0]   hs_nbyte,
    input  logic                  hs_rnw,
    input  logic [DATA_W-1:0]     hs_w_data,
    output logic [DATA_W-1:0]     hs_r_data,

    output logic                  busy,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W/8-1:0]   sram_be,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    logic                sel;       // 0 = de, 1 = hs
    logic                last;      // port served most recently
    logic                sel_rnw;
    logic                win;
    logic [DATA_W-1:0]   de_rq;
    logic [DATA_W-1:0]   hs_rq;

    // Round-robin winner: under contention the port not served last wins.
    always_comb begin
        win = hs_req;
        if (de_req && hs_req) begin
            win = ~last;
        end
    end

    // Transaction FSM with registered strobes, acks, busy and read-data holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            sel     <= 1'b0;
            sel_rnw <= 1'b0;
            de_ack  <= 1'b0;
            hs_ack  <= 1'b0;
            busy    <= 1'b0;
            sram_en <= 1'b0;
            sram_we <= 1'b0;
            de_rq   <= '0;
            hs_rq   <= '0;
        end else begin
            de_ack <= 1'b0;
            hs_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (de_req || hs_req) begin
                        sel     <= win;
                        sel_rnw <= win ? hs_rnw : de_rnw;
                        sram_en <= 1'b1;
                        sram_we <= ~(win ? hs_rnw : de_rnw);
                        busy    <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    sram_en <= 1'b0;
                    sram_we <= 1'b0;
                    if (sel) begin
                        hs_ack <= 1'b1;
                    end else begin
                        de_ack <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (sel_rnw) begin
                        if (sel) begin
                            hs_rq <= sram_rdata;
                        end else begin
                            de_rq <= sram_rdata;
                        end
                    end
                    last  <= sel;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // SRAM address/lanes/data follow the selected port, forced to zero outside the access cycle.
    always_comb begin
        sram_addr  = '0;
        sram_be    = '0;
        sram_wdata = '0;
        if (sram_en) begin
            sram_addr  = sel ? hs_addr : de_addr;
            sram_wdata = sel ? hs_w_data : de_w_data;
            sram_be    = sram_we ? ~(sel ? hs_nbyte : de_nbyte) : '1;
        end
    end

    // SRAM data only arrives in the ack cycle, so it is passed through there
    // and captured into the holding register at the end of RESP.
    always_comb begin
        de_r_data = (de_ack && sel_rnw) ? sram_rdata : de_rq;
        hs_r_data = (hs_ack && sel_rnw) ? sram_rdata : hs_rq;
    end

endmodule
